// File: rtl/microcode_sequencer_pkg.sv
// Shared constants for the microcode sequencer: microcode word field positions, opcode
// sources, counter limits and the sequencer state encoding.
package common;

  localparam int unsigned CTRL_DATA_LSB  = 0;
  localparam int unsigned CTRL_DATA_MSB  = 5;
  localparam int unsigned OUT_PLANE_LSB  = 8;
  localparam int unsigned OUT_PLANE_MSB  = 11;
  localparam int unsigned IN_PLANE_LSB   = 12;
  localparam int unsigned IN_PLANE_MSB   = 14;
  localparam int unsigned MISC_BIT       = 15;
  localparam int unsigned OPCODE_SEL_BIT = 22;

  localparam logic [2:0] IN_OPCODE = 3'd6;
  localparam logic [5:0] OP_RESET  = 6'd0;

  localparam logic OPCODE_SEL_OPWORD = 1'b0;
  localparam logic OPCODE_SEL_BUS    = 1'b1;

  localparam logic [4:0]  COUNT_MAX      = 5'd31;
  localparam logic [11:0] BOOT_LAST_ADDR = 12'd4095;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/microcode_sequencer_bootstrap_loader.sv
// Streams bytes from a valid/ready handshake into the microcode store, one write
// pulse per byte, and reports done once address 4095 has been written.
module bootstrap_loader
  import common::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_valid,
  input  logic [7:0]  boot_data,
  output logic        boot_ready,
  output logic [11:0] addr,
  output logic [7:0]  data,
  output logic        n_we,
  output logic        done
);

  seq_state_t  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      LOAD: begin
        if (boot_valid) begin
          data_d  = boot_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (addr_q == BOOT_LAST_ADDR) begin
          state_d = RUN;
        end else begin
          addr_d  = addr_q + 12'd1;
          state_d = LOAD;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  assign boot_ready = (state_q == LOAD);
  assign n_we       = (state_q != WRITE);
  assign done       = (state_q == RUN);
  assign addr       = addr_q;
  assign data       = data_q;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode address sequencer: UADDR = {opcode, count}. Define BOOTSTRAP_EN to include
// the microcode-store bootstrap loader ahead of RUN; otherwise it starts in RUN.
module microcode_sequencer
  import common::*;
(
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [31:0] UCODE,
  input  logic [31:0] BUS,
  input  logic [5:0]  OPWORD_OPCODE,
  input  logic        STALL,
  output logic [10:0] UADDR,
  output logic        FAULT,
  input  logic        BOOT_VALID,
  input  logic [7:0]  BOOT_DATA,
  output logic        BOOT_READY,
  output logic        N_BOOTED,
  output logic [11:0] BOOTSTRAP_ADDR,
  output logic [7:0]  BOOTSTRAP_DATA,
  output logic        BOOTSTRAP_N_WE
);

  logic       run;
  logic [5:0] opcode_q;
  logic [4:0] count_q;
  logic       fault_q;

  logic       misc;
  logic       opcode_sel;
  logic [2:0] in_plane;

  assign misc       = UCODE[MISC_BIT];
  assign opcode_sel = UCODE[OPCODE_SEL_BIT];
  assign in_plane   = UCODE[IN_PLANE_MSB:IN_PLANE_LSB];

`ifdef BOOTSTRAP_EN
  logic boot_done;

  bootstrap_loader u_loader (
    .clk        (CLK),
    .rst_n      (N_RST),
    .boot_valid (BOOT_VALID),
    .boot_data  (BOOT_DATA),
    .boot_ready (BOOT_READY),
    .addr       (BOOTSTRAP_ADDR),
    .data       (BOOTSTRAP_DATA),
    .n_we       (BOOTSTRAP_N_WE),
    .done       (boot_done)
  );

  assign run      = boot_done;
  assign N_BOOTED = ~boot_done;
`else
  logic unused_boot;

  assign run            = 1'b1;
  assign N_BOOTED       = 1'b0;
  assign BOOT_READY     = 1'b0;
  assign BOOTSTRAP_ADDR = '0;
  assign BOOTSTRAP_DATA = '0;
  assign BOOTSTRAP_N_WE = 1'b1;
  assign unused_boot    = ^{BOOT_VALID, BOOT_DATA};
`endif

  // Fields of the microcode word and bus that this block does not consume.
  logic unused_fields;
  assign unused_fields = ^{UCODE[CTRL_DATA_MSB:CTRL_DATA_LSB], UCODE[7:6],
                           UCODE[OUT_PLANE_MSB:OUT_PLANE_LSB], UCODE[21:16],
                           UCODE[31:23], BUS[31:6]};

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      opcode_q <= OP_RESET;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else if (run && !STALL) begin
      if (misc) begin
        count_q <= '0;
        if (in_plane == IN_OPCODE)
          opcode_q <= (opcode_sel == OPCODE_SEL_BUS) ? BUS[5:0] : OPWORD_OPCODE;
      end else if (count_q == COUNT_MAX) begin
        // Saturate rather than wrap into the next opcode's microcode.
        fault_q <= 1'b1;
      end else begin
        count_q <= count_q + 5'd1;
      end
    end
  end

  assign UADDR = {opcode_q, count_q};
  assign FAULT = fault_q;

endmodule
